// File: rtl/mv_sum_5x5_feeder.sv
// mv_sum_5x5_feeder: raster-to-line-FIFO cascade sequencer and window-sum capture; MV_FEED_ZERO_PAD_EN adds zero bottom padding rows
module mv_sum_5x5_feeder #(
  parameter int DATA_W   = 32,
  parameter int ROW_LEN  = 80,
  parameter int NUM_ROWS = 60,
  parameter int LINES    = 5
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iStart,
  input  logic              iPix_valid,
  input  logic [DATA_W-1:0] iPix_data,
  output logic              oPix_ready,
  output logic              oCore_run,
  output logic [LINES-1:0]  oCore_rdreq,
  output logic [LINES-1:0]  oCore_wrreq,
  output logic [DATA_W-1:0] oCore_data,
  input  logic [LINES-1:0]  iCore_full,
  input  logic              iCore_finish,
  input  logic [DATA_W-1:0] iCore_sum,
  output logic              oSum_valid,
  output logic [DATA_W-1:0] oSum_data,
  output logic [6:0]        oSum_row,
  output logic [6:0]        oSum_col,
  output logic              oBusy,
  output logic              oDone
);
  localparam int FW = $clog2(LINES + 1);
`ifdef MV_FEED_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DONE} state_t;
  state_t            state_q;
  logic [6:0]        row_q, col_q;
  logic [FW-1:0]     fcnt_q;
  logic              pos_v_q;
  logic [6:0]        pos_r_q, pos_c_q;
  logic              sum_v_q;
  logic [DATA_W-1:0] sum_d_q;
  logic [6:0]        sum_r_q, sum_c_q;
  logic [LINES-1:0]  wr_pat, rd_pat;
  logic              pad, feed, stall, acc, last_col, last_row, cap;
  assign wr_pat[0] = 1'b1;
  for (genvar k = 0; k < LINES - 1; k++) begin : g_pat
    assign wr_pat[k+1] = row_q > 7'(k);
    assign rd_pat[k]   = row_q > 7'(k);
  end
  assign rd_pat[LINES-1] = row_q >= 7'(LINES);
  // Zero rows are pushed through the cascade after the last real row when padding is built in.
  assign pad      = PAD_EN && state_q == FLUSH && row_q < 7'(NUM_ROWS + LINES - 1);
  assign feed     = (state_q == STREAM && iPix_valid) || pad;
  assign stall    = |(wr_pat & iCore_full & ~rd_pat);
  assign acc      = feed && !stall;
  assign last_col = col_q == 7'(ROW_LEN - 1);
  assign last_row = row_q == 7'(NUM_ROWS - 1);
  assign cap      = iCore_finish && pos_v_q && pos_r_q >= 7'(LINES - 1) && pos_c_q >= 7'(LINES - 1);
  assign oPix_ready  = state_q == STREAM && !stall;
  assign oCore_wrreq = acc ? wr_pat : '0;
  assign oCore_rdreq = acc ? rd_pat : '0;
  assign oCore_data  = (acc && state_q == STREAM) ? iPix_data : '0;
  assign oCore_run   = state_q == STREAM || state_q == FLUSH;
  assign oBusy       = state_q == CLEAR || state_q == STREAM || state_q == FLUSH;
  assign oDone       = state_q == DONE;
  assign oSum_valid  = sum_v_q;
  assign oSum_data   = sum_d_q;
  assign oSum_row    = sum_r_q;
  assign oSum_col    = sum_c_q;
  // Frame sequencing and raster position of the pixel currently offered to the cascade.
  always_ff @(posedge iClk)
    if (!iReset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      if (acc) begin
        col_q <= last_col ? '0 : col_q + 7'd1;
        if (last_col && (PAD_EN || !last_row)) row_q <= row_q + 7'd1;
      end
      case (state_q)
        IDLE, DONE: if (iStart) state_q <= CLEAR;
        CLEAR: begin
          state_q <= STREAM;
          row_q   <= '0;
          col_q   <= '0;
          fcnt_q  <= '0;
        end
        STREAM: if (acc && last_col && last_row) state_q <= FLUSH;
        FLUSH: if (!pad) begin
          fcnt_q <= fcnt_q + FW'(1);
          if (fcnt_q == FW'(LINES - 1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  // Position follows the core's one-cycle sum latency, then complete windows are registered out.
  always_ff @(posedge iClk)
    if (!iReset_n) begin
      pos_v_q <= 1'b0;
      pos_r_q <= '0;
      pos_c_q <= '0;
      sum_v_q <= 1'b0;
      sum_d_q <= '0;
      sum_r_q <= '0;
      sum_c_q <= '0;
    end else begin
      pos_v_q <= acc;
      pos_r_q <= row_q;
      pos_c_q <= col_q;
      sum_v_q <= cap;
      sum_d_q <= cap ? iCore_sum : sum_d_q;
      sum_r_q <= cap ? pos_r_q : sum_r_q;
      sum_c_q <= cap ? pos_c_q : sum_c_q;
    end
endmodule

// File: tb/tb_mv_sum_5x5_feeder.sv
// tb_mv_sum_5x5_feeder: scoreboard bench with a behavioural window-sum core model
`timescale 1ns/1ps
module tb_mv_sum_5x5_feeder;
  localparam int DW = 32, RL = 80, NR = 60, L = 5;
`ifdef MV_FEED_ZERO_PAD_EN
  localparam int OUT_ROWS = NR + L - 1;
`else
  localparam int OUT_ROWS = NR;
`endif
  localparam int NSTROBE = (OUT_ROWS - L + 1) * (RL - L + 1);
  logic          iClk = 1'b0, iReset_n = 1'b0, iStart = 1'b0, iPix_valid = 1'b0;
  logic [DW-1:0] iPix_data = '0;
  logic [L-1:0]  iCore_full = '0;
  logic          iCore_finish = 1'b0;
  logic [DW-1:0] iCore_sum = '0;
  logic          oPix_ready, oCore_run, oSum_valid, oBusy, oDone;
  logic [L-1:0]  oCore_rdreq, oCore_wrreq;
  logic [DW-1:0] oCore_data, oSum_data;
  logic [6:0]    oSum_row, oSum_col;
  typedef struct {int row; int col; int sum;} exp_t;
  exp_t exp_q[$];
  exp_t e_m;
  int   img_m[$];
  int   wr_cyc[$];
  int   total = 0, bad = 0, cyc = 0, nstrobe = 0, idx;
  bit   feeding = 1'b0;
  mv_sum_5x5_feeder dut (
    .iClk(iClk), .iReset_n(iReset_n), .iStart(iStart), .iPix_valid(iPix_valid), .iPix_data(iPix_data),
    .oPix_ready(oPix_ready), .oCore_run(oCore_run), .oCore_rdreq(oCore_rdreq), .oCore_wrreq(oCore_wrreq),
    .oCore_data(oCore_data), .iCore_full(iCore_full), .iCore_finish(iCore_finish), .iCore_sum(iCore_sum),
    .oSum_valid(oSum_valid), .oSum_data(oSum_data), .oSum_row(oSum_row), .oSum_col(oSum_col),
    .oBusy(oBusy), .oDone(oDone)
  );
  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;
  task automatic chk(input string nm, input longint a, input longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  // Core model: keeps every written pixel; one cycle after a write whose column closes a
  // window it raises finish with the 5x5 sum ending at that pixel (rows above the image count as absent).
  always @(posedge iClk) begin
    iCore_finish <= 1'b0;
    if (!oCore_run) img_m.delete();
    else if (oCore_wrreq[0]) begin
      int n, r, c, s;
      n = img_m.size();
      img_m.push_back(int'(oCore_data));
      r = n / RL;
      c = n % RL;
      if (c >= L - 1) begin
        s = 0;
        for (int rr = (r >= L - 1 ? r - L + 1 : 0); rr <= r; rr++)
          for (int cc = c - L + 1; cc <= c; cc++) s += img_m[rr * RL + cc];
        iCore_finish <= 1'b1;
        iCore_sum    <= DW'(s);
      end
    end
  end
  // Monitor: write timestamps, protocol invariants, scoreboard pops on each strobe.
  always @(negedge iClk) begin
    if (!oCore_run) wr_cyc.delete();
    else if (oCore_wrreq[0]) wr_cyc.push_back(cyc);
    if (iReset_n) chk("busy_done_exclusive", oBusy && oDone, 0);
    if (feeding) begin
      chk("no_bubble", (|oCore_wrreq) || (|oCore_rdreq), iPix_valid && oPix_ready);
      if (iPix_valid && oPix_ready) chk("core_data", oCore_data, iPix_data);
    end
    if (oSum_valid) begin
      nstrobe++;
      if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e_m = exp_q.pop_front();
        chk("sum_row", oSum_row, e_m.row);
        chk("sum_col", oSum_col, e_m.col);
        chk("sum_data", oSum_data, e_m.sum);
        idx = int'(oSum_row) * RL + int'(oSum_col);
        chk("latency", idx < wr_cyc.size() ? cyc - wr_cyc[idx] : -1, 2);
      end
    end
  end
  // mode 0: all ones, 1: pixel = column, 2: random. gap 0: always valid, 1: one in three, 2: random.
  task automatic run_frame(input int mode, input int gap, input bit bp, input bit poke);
    int img[RL*NR];
    int n, cy, k, nr, s, bp_left;
    bit took, bp_done;
    for (int i = 0; i < RL * NR; i++) img[i] = mode == 0 ? 1 : mode == 1 ? i % RL : int'($urandom_range(0, 1000));
    for (int r = L - 1; r < OUT_ROWS; r++)
      for (int c = L - 1; c < RL; c++) begin
        nr = (r < NR - 1 ? r : NR - 1) - (r - L + 1) + 1;
        if (mode == 0) s = nr * 5;
        else if (mode == 1) s = nr * (5 * c - 10);
        else begin
          s = 0;
          for (int rr = r - L + 1; rr <= r && rr < NR; rr++)
            for (int cc = c - L + 1; cc <= c; cc++) s += img[rr * RL + cc];
        end
        exp_q.push_back('{r, c, s});
      end
    nstrobe = 0;
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    n = 0; cy = 0; bp_left = 0; bp_done = 1'b0;
    feeding = 1'b1;
    while (n < RL * NR && cy < 40000) begin
      iPix_valid = gap == 0 ? 1'b1 : gap == 1 ? (cy % 3 == 0) : ($urandom_range(0, 1) == 0);
      iPix_data  = DW'(img[n]);
      if (bp && !bp_done && bp_left == 0 && n == 2 * RL + 10) bp_left = 10;
      iCore_full = bp_left > 0 ? 5'b00100 : 5'b00000;
      iStart     = poke && n == 1000;
      @(negedge iClk);
      took = iPix_valid && oPix_ready;
      if (bp_left > 0) begin
        chk("stall_ready", oPix_ready, 0);
        chk("stall_wrreq2", oCore_wrreq[2], 0);
        bp_left--;
        bp_done = bp_left == 0;
      end
      @(posedge iClk); #1;
      if (took) n++;
      cy++;
    end
    feeding = 1'b0;
    iPix_valid = 1'b0;
    iCore_full = '0;
    iStart = 1'b0;
    chk("pixels_accepted", n, RL * NR);
    k = 0;
    while (!oDone && k < 1000) begin
      @(posedge iClk); #1;
      k++;
    end
    chk("done", oDone, 1);
    chk("busy_at_done", oBusy, 0);
    chk("strobe_count", nstrobe, NSTROBE);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ctl"}, {oCore_run, oPix_ready, oCore_rdreq, oCore_wrreq, oSum_valid, oBusy, oDone}, 0);
    chk({nm, "_cdata"}, oCore_data, 0);
    chk({nm, "_sum"}, oSum_data, 0);
    chk({nm, "_pos"}, {oSum_row, oSum_col}, 0);
  endtask
  initial begin
    repeat (3) @(posedge iClk);
    #1;
    check_reset_outputs("reset_init");
    iReset_n = 1'b1;
    @(posedge iClk); #1;
    run_frame(0, 0, 1'b0, 1'b0);
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    iPix_valid = 1'b1;
    repeat (100) begin
      iPix_data = DW'($urandom_range(0, 1000));
      @(posedge iClk); #1;
    end
    iReset_n = 1'b0;
    repeat (3) begin
      @(posedge iClk); #1;
      check_reset_outputs("reset_mid");
    end
    iPix_valid = 1'b0;
    iReset_n = 1'b1;
    @(posedge iClk); #1;
    run_frame(1, 0, 1'b0, 1'b0);
    run_frame(0, 0, 1'b1, 1'b0);
    run_frame(0, 1, 1'b0, 1'b0);
    run_frame(2, 2, 1'b1, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
